// File: rtl/dct_pkg.sv
// Shared definitions for the DCT serial-stream receiver and transmitter.
package dct_pkg;

    localparam int unsigned IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Transform size code to number of coefficient words per frame.
    function automatic logic [IDX_W:0] size_to_words(input logic [2:0] code);
        case (code)
            3'd0:    return 6'd4;
            3'd1:    return 6'd8;
            3'd2:    return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/dct_sfifo.sv
// Parameterised synchronous FIFO with count-based full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module dct_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Head word is gated to zero when empty so outputs read 0 after reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dct_sdat_deser.sv
// Serial-to-parallel receiver for the DCT core SDAT/SVAL stream.
// Words arrive MSB first; completed words are queued with their frame index
// and a last-word flag, then handed out through a valid/ready port.
module dct_sdat_deser
    import dct_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iSDAT,
    input  logic             iSVAL,
    input  logic [2:0]       iSize,
    output logic [W-1:0]     oData,
    output logic [IDX_W-1:0] oIdx,
    output logic             oLast,
    output logic             oValid,
    input  logic             iReady,
    output logic             oOvf,
    output logic             oFrameErr
);

    localparam int unsigned BW = $clog2(W);
    localparam int unsigned FW = W + IDX_W + 1;

    state_t              state, state_nxt;
    logic                err_nxt;
    logic [W-2:0]        shreg;
    logic [BW-1:0]       bit_cnt;
    logic [IDX_W:0]      word_cnt;
    logic [IDX_W:0]      n_words;
    logic [W-1:0]        word_nxt;
    logic                frame_done;
    logic                start;
    logic                push;
    logic                is_last;
    logic [FW-1:0]       fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign word_nxt   = {shreg, iSDAT};
    assign frame_done = (word_cnt == n_words);
    // A frame starts from IDLE, or directly after the final word of the previous one.
    assign start      = iSVAL && ((state == IDLE) || frame_done);
    assign push       = (state == RECV) && iSVAL && !frame_done && (bit_cnt == BW'(W - 1));
    assign is_last    = (word_cnt == n_words - 1'b1);

    // Next-state and frame-error decision.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (iSVAL) state_nxt = RECV;
            RECV: begin
                if (!iSVAL) begin
                    state_nxt = IDLE;
                    err_nxt   = !frame_done;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered frame-error pulse.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            oFrameErr <= 1'b0;
        end else begin
            state     <= state_nxt;
            oFrameErr <= err_nxt;
        end
    end

    // Bit shifting and bit/word counting; a new frame discards any partial word.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            n_words  <= '0;
        end else if (start) begin
            n_words  <= size_to_words(iSize);
            shreg    <= (W - 1)'(iSDAT);
            bit_cnt  <= BW'(1);
            word_cnt <= '0;
        end else if ((state == RECV) && iSVAL) begin
            shreg <= word_nxt[W-2:0];
            if (bit_cnt == BW'(W - 1)) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Sticky overflow: a completed word found the FIFO full with no pop.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oOvf <= 1'b0;
        end else if (push && fifo_full && !(iReady && !fifo_empty)) begin
            oOvf <= 1'b1;
        end
    end

    dct_sfifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (push),
        .wdata ({word_nxt, word_cnt[IDX_W-1:0], is_last}),
        .pop   (iReady),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {oData, oIdx, oLast} = fifo_rdata;
    assign oValid               = (fifo_count != '0);

endmodule

// File: tb/tb_dct_sdat_deser.sv
// Randomised scoreboard bench for dct_sdat_deser.
module tb_dct_sdat_deser;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic        iClk   = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iSDAT  = 1'b0;
    logic        iSVAL  = 1'b0;
    logic        iReady = 1'b0;
    logic [2:0]  iSize  = 3'd0;
    logic [15:0] oData;
    logic [4:0]  oIdx;
    logic        oLast, oValid, oOvf, oFrameErr;

    dct_sdat_deser #(.W(W), .DEPTH(DEPTH)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iSDAT(iSDAT), .iSVAL(iSVAL), .iSize(iSize),
        .oData(oData), .oIdx(oIdx), .oLast(oLast), .oValid(oValid), .iReady(iReady),
        .oOvf(oOvf), .oFrameErr(oFrameErr)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  idx;
        logic        last;
    } entry_t;

    entry_t      exp_q[$];
    int          occ = 0;
    bit          exp_ovf = 0;
    bit          exp_err = 0;
    logic        push_now = 1'b0;
    logic        err_now  = 1'b0;
    entry_t      push_entry = '0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] fw[32];
    int          rmode_a = 1;
    int          rmode_b = 1;

    function automatic int words_for(input int code);
        return (code <= 3) ? (4 << code) : 32;
    endfunction

    // Ready modes: 0 low, 1 high, 2 random, 3 high only on word-completion cycles.
    function automatic logic pick_ready(input int mode, input logic pn);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            default: return pn;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic sval, input logic sdat, input logic [2:0] size,
                       input logic rdy, input logic pn, input entry_t pe, input logic en);
        @(posedge iClk);
        #2;
        iSVAL = sval; iSDAT = sdat; iSize = size; iReady = rdy;
        push_now = pn; push_entry = pe; err_now = en;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, iSize, pick_ready(rmode_b, 1'b0), 1'b0, '0, 1'b0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 32; i++) fw[i] = 16'($urandom);
    endtask

    // Sends nbits of a frame built from fw[]; end_idle adds one SVAL-low cycle,
    // which is a frame error when the frame was cut short.
    task automatic send_frame(input int code, input int nbits, input bit end_idle);
        int n;
        n = words_for(code);
        for (int b = 0; b < nbits; b++) begin
            int     k;
            int     j;
            entry_t e;
            logic   pn;
            k = b / 16;
            j = b % 16;
            pn = (j == 15);
            e.data = fw[k];
            e.idx  = 5'(k);
            e.last = (k == n - 1);
            cyc(1'b1, fw[k][15-j], 3'(code), pick_ready((k < 4) ? rmode_a : rmode_b, pn), pn, e, 1'b0);
        end
        if (end_idle)
            cyc(1'b0, 1'b0, 3'(code), pick_ready(rmode_b, 1'b0), 1'b0, '0, nbits < n * 16);
    endtask

    task automatic do_reset(input int n);
        @(posedge iClk);
        #2;
        iRst_n = 1'b0; iSVAL = 1'b0; iSDAT = 1'b0; push_now = 1'b0; err_now = 1'b0;
        repeat (n) @(posedge iClk);
        #2;
        iRst_n = 1'b1;
    endtask

    // Reference model: FIFO occupancy, drop/overflow and error expectations.
    initial begin
        forever begin
            @(posedge iClk or negedge iRst_n);
            if (!iRst_n) begin
                occ = 0;
                exp_q.delete();
                exp_ovf = 0;
                exp_err = 0;
            end else begin
                bit pop;
                pop = (occ > 0) && iReady;
                exp_err = err_now;
                if (push_now) begin
                    if (occ < DEPTH || pop) begin
                        exp_q.push_back(push_entry);
                        occ++;
                    end else begin
                        exp_ovf = 1;
                    end
                end
                if (pop) occ--;
            end
        end
    end

    // Monitor: compares outputs on the falling edge, pops on accepted transfers.
    initial begin
        forever begin
            @(negedge iClk);
            if (!iRst_n) begin
                check("reset_outputs", 32'({oData, oIdx, oLast, oValid, oOvf, oFrameErr}), 32'd0);
            end else begin
                check("valid", 32'(oValid), 32'(occ != 0));
                check("ovf", 32'(oOvf), 32'(exp_ovf));
                check("frame_err", 32'(oFrameErr), 32'(exp_err));
                if (oValid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected no word at %0t", oData, $time);
                    end else begin
                        check("data", 32'(oData), 32'(exp_q[0].data));
                        check("idx", 32'(oIdx), 32'(exp_q[0].idx));
                        check("last", 32'(oLast), 32'(exp_q[0].last));
                        if (iReady) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge iClk);
        #2;
        iRst_n = 1'b1;
        idle(2);

        // Four-word frame with fixed words, consumer always ready.
        rmode_a = 1; rmode_b = 1;
        fw[0] = 16'h1234; fw[1] = 16'h8001; fw[2] = 16'hFFFF; fw[3] = 16'h0000;
        send_frame(0, 64, 1'b1);
        idle(3);

        // Two back-to-back 8-word frames.
        rand_words();
        send_frame(1, 128, 1'b0);
        rand_words();
        send_frame(1, 128, 1'b1);
        idle(3);

        // Frame cut after 40 bits, then a clean frame.
        rand_words();
        send_frame(0, 40, 1'b1);
        idle(2);
        rand_words();
        send_frame(0, 64, 1'b1);
        idle(3);

        // Fill the FIFO, then every later push coincides with a pop.
        rmode_a = 0; rmode_b = 3;
        rand_words();
        send_frame(2, 256, 1'b1);
        rmode_a = 1; rmode_b = 1;
        idle(8);

        // Consumer stalled through an 8-word frame: four kept, four dropped.
        rmode_a = 0; rmode_b = 0;
        rand_words();
        send_frame(1, 128, 1'b1);
        idle(4);
        rmode_a = 1; rmode_b = 1;
        idle(8);

        // Reset at bit 9 of word 2, then a full 32-word frame.
        rmode_a = 0; rmode_b = 0;
        rand_words();
        send_frame(3, 41, 1'b0);
        do_reset(2);
        rmode_a = 1; rmode_b = 1;
        idle(2);
        rand_words();
        send_frame(3, 512, 1'b1);
        idle(4);

        // Random frames: any size code, random truncation and consumer stalls.
        rmode_a = 2; rmode_b = 2;
        for (int f = 0; f < 8; f++) begin
            int code;
            int n;
            int nb;
            code = $urandom_range(0, 7);
            n = words_for(code);
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * 16 - 1) : n * 16;
            rand_words();
            send_frame(code, nb, (nb < n * 16) || ($urandom_range(0, 1) == 1));
        end
        rmode_a = 1; rmode_b = 1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_sdat_deser.md
# dct_sdat_deser

Serial-to-parallel receiver for the DCT core's serial output stream (SDAT/SVAL bit-serial protocol). It samples a frame of coefficient words arriving MSB-first on a one-bit data line qualified by a frame-valid strobe. It assembles each word and buffers completed words in a small FIFO. Words are presented to a parallel consumer through a valid/ready handshake. It sits between the DCT core's serial output and the logic-analyzer/Wishbone readback path of the user project.

## Interface
- W, 16, coefficient word width in bits
- DEPTH, 4, FIFO depth in words (power of two, ≥2)
- iClk  input  1  single clock; all logic is rising-edge
- iRst_n  input  1  asynchronous, active-low reset
- iSDAT  input  1  serial data bit, MSB of each word first
- iSVAL  input  1  frame valid; high for every bit cycle of a frame
- iSize  input  3  transform size code, sampled at frame start: 0→4, 1→8, 2→16, 3→32 words; 4–7 treated as 32
- oData  output  W  word at FIFO head
- oIdx  output  5  word index within frame of oData (0..N-1)
- oLast  output  1  oData is the final word of its frame
- oValid  output  1  FIFO non-empty
- iReady  input  1  consumer accepts oData when oValid & iReady
- oOvf  output  1  sticky: a completed word was dropped because the FIFO was full
- oFrameErr  output  1  one-cycle pulse: iSVAL fell before the frame completed

## Operation
- States: IDLE, RECV.
- IDLE: on iSVAL=1, latch N from iSize and sample the first bit (bit counter → 1, word counter → 0); go to RECV. No bit is lost on the start cycle.
- RECV, iSVAL=1: shift iSDAT into the LSB of the shift register; bit counter increments.
  - On the W-th bit, the word is complete. Push {word, word index, last = (index == N-1)} to the FIFO. Clear the bit counter and increment the word counter.
  - After word N-1 completes: if iSVAL stays high on the next cycle, that cycle is bit 0 of a new frame. iSize is re-sampled and the state stays RECV (back-to-back frames). Otherwise go to IDLE.
- RECV, iSVAL=0 before N words are complete: pulse oFrameErr for one cycle and go to IDLE.
  - Discard any partial word.
  - Already-pushed words remain in the FIFO; none carries oLast.
- FIFO: synchronous read and write, DEPTH entries, count-based full/empty.
  - Push while full and no pop in the same cycle: the word is dropped and oOvf sets. oOvf clears only on reset.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
- oData, oIdx and oLast are stable while oValid=1 and iReady=0.
- Reset (any time, including mid-frame): state → IDLE; counters, FIFO pointers and count → 0; all outputs → 0 (oData=0, oIdx=0, oLast=0, oValid=0, oOvf=0, oFrameErr=0). A frame in progress is abandoned. Reception restarts on the next iSVAL high after reset deasserts.

## Timing
- Latency: if the last bit of a word is sampled at edge t and the FIFO is empty, oValid=1 with that word after edge t (visible in cycle t+1).
- Throughput: one bit per cycle; one word per W cycles. With iReady held high the FIFO never exceeds 1 entry.
- oFrameErr asserts in the cycle after the edge that samples iSVAL=0 mid-frame.
- oValid/oData are registered (from FIFO storage); there is no combinational path from iSDAT/iSVAL to any output.

## Structure
- Shared package dct_pkg holds:
  - the size-code→word-count function;
  - the width constant for the word index (5);
  - the state enum {IDLE, RECV}.
- One sub-module, dct_sfifo: a parameterised synchronous FIFO (width, depth) with push/pop/full/empty/count. It is reusable by the matching transmitter.

## Test plan
- iSize=0, iSVAL high 64 cycles, words 0x1234, 0x8001, 0xFFFF, 0x0000, iReady=1 → four outputs in order with oIdx 0..3; oLast only on 0x0000; each oValid 1 cycle after its 16th bit.
- Back-to-back: two iSize=1 frames (8 words each) with iSVAL continuously high for 256 cycles → 16 words; oLast on words 7 and 15; oIdx wraps 7→0.
- iSVAL drops after 40 bits of an iSize=0 frame → words 0 and 1 delivered, oLast never set, oFrameErr single pulse, 8 partial bits discarded; the next frame is received correctly.
- iReady=0 through an iSize=1 frame with DEPTH=4 → first 4 words held in order, words 4–7 dropped, oOvf=1 and sticky. Then iReady=1 → exactly 4 words popped.
- Full FIFO with a simultaneous push and pop → no drop, oOvf stays 0, ordering preserved.
- Reset asserted at bit 9 of word 2 → all outputs 0 immediately. The FIFO is empty after release, and a fresh iSize=3 frame delivers 32 words with oIdx 0..31.
